// File: rtl/uidbufirq_mc.sv
// ---------------------------------------------------------------------------
// uidbufirq_mc
//   Multi-channel interrupt/status controller for the frame-buffer DMA path.
//   Each FDMA channel reports a one-cycle frame-done pulse together with the
//   index of the buffer it just finished. This block latches those events
//   into sticky W1C status bits, keeps per-channel frame and missed-IRQ
//   counters, and drives one aggregated, registered level interrupt. The CPU
//   reaches everything through an AXI4-Lite slave.
//
// Register map (byte address, addr[1:0] ignored):
//   0x00 STATUS   [CH-1:0] sticky, write 1 to clear
//   0x04 ENABLE   [CH-1:0] per-channel interrupt mask
//   0x08 CTRL     bit0 global enable, bit1 write-1 clears all counters (reads 0)
//   0x0C ID       {VERSION[31:8], 4'd0, CHANNELS[3:0]}
//   0x10+4*n CHn  {frame[15:0], missed[7:0], last_buf[7:0]}; any write clears missed
//   Anything else reads 0 and ignores writes. RESP is always OKAY.
//
// Ports:
//   S_AXI_ACLK      single clock for the bus and all channel inputs
//   S_AXI_ARESETN   asynchronous active-low reset
//   S_AXI_AW*/W*/B* AXI4-Lite write address/data/response channels
//   S_AXI_AR*/R*    AXI4-Lite read address/data channels
//   ch_irq_i        per-channel frame-done pulse (one cycle per event)
//   ch_buf_i        per-channel buffer index, 8 bits each, sampled with ch_irq_i
//   irq_o           registered level interrupt
// ---------------------------------------------------------------------------
module uidbufirq_mc #(
  parameter int          CHANNELS   = 4,
  parameter int          ADDR_WIDTH = 6,
  parameter logic [31:0] VERSION    = 32'h0301_0000
) (
  input  logic                    S_AXI_ACLK,
  input  logic                    S_AXI_ARESETN,
  // write address
  input  logic [ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]              S_AXI_AWPROT,
  input  logic                    S_AXI_AWVALID,
  output logic                    S_AXI_AWREADY,
  // write data
  input  logic [31:0]             S_AXI_WDATA,
  input  logic [3:0]              S_AXI_WSTRB,
  input  logic                    S_AXI_WVALID,
  output logic                    S_AXI_WREADY,
  // write response
  output logic [1:0]              S_AXI_BRESP,
  output logic                    S_AXI_BVALID,
  input  logic                    S_AXI_BREADY,
  // read address
  input  logic [ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]              S_AXI_ARPROT,
  input  logic                    S_AXI_ARVALID,
  output logic                    S_AXI_ARREADY,
  // read data
  output logic [31:0]             S_AXI_RDATA,
  output logic [1:0]              S_AXI_RRESP,
  output logic                    S_AXI_RVALID,
  input  logic                    S_AXI_RREADY,
  // channel inputs
  input  logic [CHANNELS-1:0]     ch_irq_i,
  input  logic [8*CHANNELS-1:0]   ch_buf_i,
  // interrupt
  output logic                    irq_o
);

  // -------------------------------------------------------------------------
  // Handshake rules (valid/ready):
  //   A transfer happens on the rising edge where both VALID and READY are
  //   high. VALID, once raised, stays high with stable payload until that
  //   edge. READY here is a registered one-cycle pulse: AWREADY/WREADY are
  //   raised together only when AWVALID and WVALID are both present and no
  //   write response is outstanding; ARREADY only when ARVALID is present and
  //   no read data is outstanding. The register file commits a write on the
  //   handshake edge, and BVALID/RVALID rise on that same edge (visible the
  //   cycle after the READY pulse), holding until BREADY/RREADY.
  // -------------------------------------------------------------------------

  localparam int WORD_W = ADDR_WIDTH - 2;

  localparam logic [WORD_W-1:0] W_STATUS = WORD_W'(0);
  localparam logic [WORD_W-1:0] W_ENABLE = WORD_W'(1);
  localparam logic [WORD_W-1:0] W_CTRL   = WORD_W'(2);
  localparam logic [WORD_W-1:0] W_ID     = WORD_W'(3);

  // bus state
  logic                  aw_ready_q;
  logic                  ar_ready_q;
  logic                  b_valid_q;
  logic                  r_valid_q;
  logic [31:0]           r_data_q;

  // register file
  logic [CHANNELS-1:0]   status_q;
  logic [CHANNELS-1:0]   status_d;
  logic [CHANNELS-1:0]   enable_q;
  logic                  ctrl_en_q;
  logic                  irq_q;
  logic [7:0]            buf_q    [CHANNELS];
  logic [7:0]            buf_d    [CHANNELS];
  logic [7:0]            missed_q [CHANNELS];
  logic [7:0]            missed_d [CHANNELS];
  logic [15:0]           frame_q  [CHANNELS];
  logic [15:0]           frame_d  [CHANNELS];

  // decode
  logic                  wr_en;
  logic                  rd_en;
  logic                  wr_byte0;
  logic                  clr_cnt;
  logic [WORD_W-1:0]     wr_word;
  logic [WORD_W-1:0]     rd_word;
  logic [CHANNELS-1:0]   w1c;
  logic [CHANNELS-1:0]   ch_wr;
  logic [31:0]           rd_mux;

  // PROT, the byte offset and the upper strobes carry no meaning here; every
  // register field lives in byte 0 or is read-only.
  logic                  unused_ok;
  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0],
                       S_AXI_ARADDR[1:0], S_AXI_WDATA, S_AXI_WSTRB[3:1]};

  assign wr_word = S_AXI_AWADDR[ADDR_WIDTH-1:2];
  assign rd_word = S_AXI_ARADDR[ADDR_WIDTH-1:2];

  // READY is only ever high while both valids were present, but gating with
  // the valids keeps a misbehaving master from committing a phantom write.
  assign wr_en    = aw_ready_q & S_AXI_AWVALID & S_AXI_WVALID;
  assign rd_en    = ar_ready_q & S_AXI_ARVALID;
  assign wr_byte0 = wr_en & S_AXI_WSTRB[0];

  // -------------------------------------------------------------------------
  // Write decode
  // -------------------------------------------------------------------------
  always_comb begin
    clr_cnt = wr_byte0 && (wr_word == W_CTRL) && S_AXI_WDATA[1];
    w1c     = '0;
    ch_wr   = '0;
    for (int n = 0; n < CHANNELS; n++) begin
      w1c[n]   = wr_byte0 && (wr_word == W_STATUS) && S_AXI_WDATA[n];
      // Any write to a channel word clears its missed count, whatever WSTRB.
      ch_wr[n] = wr_en && (wr_word == WORD_W'(4 + n));
    end
  end

  // -------------------------------------------------------------------------
  // Per-channel event logic
  //   Order of precedence inside one cycle:
  //     1. counter clears (CTRL bit1 for all, CHn write for missed only)
  //     2. the channel event counts on top of the cleared value
  //     3. a new event beats a W1C on the same status bit, and in that case
  //        the event is not treated as missed because software was in the
  //        act of acknowledging the previous one.
  // -------------------------------------------------------------------------
  always_comb begin
    status_d = status_q;
    for (int n = 0; n < CHANNELS; n++) begin
      buf_d[n]    = buf_q[n];
      frame_d[n]  = clr_cnt ? 16'd0 : frame_q[n];
      missed_d[n] = (clr_cnt || ch_wr[n]) ? 8'd0 : missed_q[n];
      if (ch_irq_i[n]) begin
        status_d[n] = 1'b1;
        buf_d[n]    = ch_buf_i[8*n +: 8];
        frame_d[n]  = frame_d[n] + 16'd1;   // wraps at 0xFFFF
        if (status_q[n] && !w1c[n] && (missed_d[n] != 8'hFF)) begin
          missed_d[n] = missed_d[n] + 8'd1;
        end
      end else if (w1c[n]) begin
        status_d[n] = 1'b0;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Read mux
  // -------------------------------------------------------------------------
  always_comb begin
    rd_mux = '0;
    case (rd_word)
      W_STATUS: rd_mux[CHANNELS-1:0] = status_q;
      W_ENABLE: rd_mux[CHANNELS-1:0] = enable_q;
      W_CTRL:   rd_mux[0]            = ctrl_en_q;
      W_ID:     rd_mux = {VERSION[31:8], 4'd0, 4'(CHANNELS)};
      default: begin
        for (int n = 0; n < CHANNELS; n++) begin
          if (rd_word == WORD_W'(4 + n)) begin
            rd_mux = {frame_q[n], missed_q[n], buf_q[n]};
          end
        end
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // AXI-Lite handshake registers
  // -------------------------------------------------------------------------
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      aw_ready_q <= 1'b0;
      ar_ready_q <= 1'b0;
      b_valid_q  <= 1'b0;
      r_valid_q  <= 1'b0;
      r_data_q   <= '0;
    end else begin
      // Single-cycle pulse: the !aw_ready_q term drops it after the handshake.
      aw_ready_q <= !aw_ready_q && S_AXI_AWVALID && S_AXI_WVALID && !b_valid_q;
      ar_ready_q <= !ar_ready_q && S_AXI_ARVALID && !r_valid_q;

      if (wr_en) begin
        b_valid_q <= 1'b1;
      end else if (S_AXI_BREADY) begin
        b_valid_q <= 1'b0;
      end

      if (rd_en) begin
        r_valid_q <= 1'b1;
        r_data_q  <= rd_mux;
      end else if (S_AXI_RREADY) begin
        r_valid_q <= 1'b0;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Register file and interrupt
  // -------------------------------------------------------------------------
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      status_q  <= '0;
      enable_q  <= '0;
      ctrl_en_q <= 1'b0;
      irq_q     <= 1'b0;
      for (int n = 0; n < CHANNELS; n++) begin
        buf_q[n]    <= '0;
        missed_q[n] <= '0;
        frame_q[n]  <= '0;
      end
    end else begin
      status_q <= status_d;
      for (int n = 0; n < CHANNELS; n++) begin
        buf_q[n]    <= buf_d[n];
        missed_q[n] <= missed_d[n];
        frame_q[n]  <= frame_d[n];
      end
      if (wr_byte0 && (wr_word == W_ENABLE)) begin
        enable_q <= S_AXI_WDATA[CHANNELS-1:0];
      end
      if (wr_byte0 && (wr_word == W_CTRL)) begin
        ctrl_en_q <= S_AXI_WDATA[0];
      end
      // Built from the registered status, so a new event shows on irq_o two
      // cycles after its pulse and a W1C drops it one cycle after the write.
      irq_q <= ctrl_en_q & (|(status_q & enable_q));
    end
  end

  assign S_AXI_AWREADY = aw_ready_q;
  assign S_AXI_WREADY  = aw_ready_q;
  assign S_AXI_BVALID  = b_valid_q;
  assign S_AXI_BRESP   = 2'b00;
  assign S_AXI_ARREADY = ar_ready_q;
  assign S_AXI_RVALID  = r_valid_q;
  assign S_AXI_RDATA   = r_data_q;
  assign S_AXI_RRESP   = 2'b00;
  assign irq_o         = irq_q;

endmodule

// File: tb/tb_uidbufirq_mc.sv
// ---------------------------------------------------------------------------
// tb_uidbufirq_mc
//   Self-checking bench for uidbufirq_mc (CHANNELS=4, ADDR_WIDTH=6).
//   A register-level reference model tracks status/enable/counters from the
//   register-map rules; reads are predicted at their handshake edge and
//   queued, irq_o is compared every cycle.
// ---------------------------------------------------------------------------
module tb_uidbufirq_mc;
  localparam int CH = 4;
  localparam int AW = 6;
  localparam logic [31:0] ID_VAL  = 32'h0301_0004;
  localparam logic [7:0]  CH_MASK = 8'h0F;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [AW-1:0]   awaddr, araddr;
  logic [2:0]      awprot, arprot;
  logic            awvalid, awready, wvalid, wready, bvalid, bready;
  logic            arvalid, arready, rvalid, rready, irq_o;
  logic [31:0]     wdata, rdata;
  logic [3:0]      wstrb;
  logic [1:0]      bresp, rresp;
  logic [CH-1:0]   ch_irq;
  logic [8*CH-1:0] ch_buf;

  uidbufirq_mc #(.CHANNELS(CH), .ADDR_WIDTH(AW), .VERSION(32'h0301_0000)) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .ch_irq_i(ch_irq), .ch_buf_i(ch_buf), .irq_o(irq_o)
  );

  // scoreboard
  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // reference model
  logic [7:0] m_status, m_enable;
  logic       m_ctrl, m_irq;
  int         m_frame[CH];
  int         m_missed[CH];
  logic [7:0] m_buf[CH];

  task automatic model_reset();
    m_status = '0; m_enable = '0; m_ctrl = 1'b0; m_irq = 1'b0;
    for (int n = 0; n < CH; n++) begin
      m_frame[n] = 0; m_missed[n] = 0; m_buf[n] = '0;
    end
  endtask

  function automatic logic [31:0] model_read(input logic [AW-1:0] a);
    int word;
    word = int'(a) / 4;
    if (word == 0) return {24'd0, m_status};
    if (word == 1) return {24'd0, m_enable};
    if (word == 2) return {31'd0, m_ctrl};
    if (word == 3) return ID_VAL;
    if (word >= 4 && word < 4 + CH)
      return {16'(m_frame[word-4]), 8'(m_missed[word-4]), m_buf[word-4]};
    return 32'd0;
  endfunction

  // One clock edge of the model: events, a committed write (if any), irq.
  task automatic model_update(input logic [CH-1:0] ev, input logic wr, input logic [AW-1:0] a,
                              input logic [31:0] d, input logic [3:0] s, input logic [8*CH-1:0] bufs);
    int   word;
    logic nxt_irq, clr, w1c;
    nxt_irq = m_ctrl && ((m_status & m_enable) != 8'd0);
    word = wr ? int'(a) / 4 : -1;
    clr = (word == 2) && s[0] && d[1];
    for (int n = 0; n < CH; n++) begin
      w1c = (word == 0) && s[0] && d[n];
      if (clr) begin m_frame[n] = 0; m_missed[n] = 0; end
      if (word == 4 + n) m_missed[n] = 0;
      if (ev[n]) begin
        if (m_status[n] && !w1c) m_missed[n] = (m_missed[n] >= 255) ? 255 : m_missed[n] + 1;
        m_frame[n]  = (m_frame[n] + 1) % 65536;
        m_buf[n]    = bufs[8*n +: 8];
        m_status[n] = 1'b1;
      end else if (w1c) begin
        m_status[n] = 1'b0;
      end
    end
    if (word == 1 && s[0]) m_enable = d[7:0] & CH_MASK;
    if (word == 2 && s[0]) m_ctrl = d[0];
    m_irq = nxt_irq;
  endtask

  // driver: one cycle, entered and left at the falling edge
  logic          rand_ev = 1'b0;
  logic [CH-1:0] ev_next = '0;
  logic [7:0]    buf_next = '0;

  task automatic tick();
    logic wr, rd;
    if (rand_ev) begin
      ch_irq = ($urandom_range(0, 3) == 0) ? CH'($urandom) : '0;
      ch_buf = $urandom;
    end else begin
      ch_irq = ev_next;
      ch_buf = {CH{buf_next}};
    end
    ev_next = '0;
    wr = awready & awvalid & wvalid;
    rd = arready & arvalid;
    if (rd) exp_q.push_back(model_read(araddr));
    @(posedge clk);
    model_update(ch_irq, wr, awaddr, wdata, wstrb, ch_buf);
    @(negedge clk);
    check("irq_o", {31'd0, irq_o}, {31'd0, m_irq});
  endtask

  task automatic axi_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s,
                           input logic [CH-1:0] ev_commit);
    int n;
    n = 0;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
    while (!awready && n < 20) begin tick(); n++; end
    check("wr_ready", {30'd0, awready, wready}, 32'd3);
    ev_next = ev_commit;
    tick();
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
    check("bvalid_resp", {29'd0, bvalid, bresp}, 32'h4);
    tick();
    bready = 1'b0;
  endtask

  task automatic axi_read(input logic [AW-1:0] a, output logic [31:0] d);
    int n;
    n = 0;
    araddr = a; arvalid = 1'b1;
    while (!arready && n < 20) begin tick(); n++; end
    check("ar_ready", {31'd0, arready}, 32'd1);
    tick();
    arvalid = 1'b0; rready = 1'b1;
    check("rvalid_resp", {29'd0, rvalid, rresp}, 32'h4);
    d = rdata;
    if (exp_q.size() > 0) begin
      check("rdata_model", rdata, exp_q.pop_front());
    end else begin
      checks++; failures++;
      $display("FAIL rd_queue actual=empty required=prediction t=%0t", $time);
    end
    tick();
    rready = 1'b0;
  endtask

  typedef struct {
    logic          do_wr;
    logic [AW-1:0] waddr;
    logic [31:0]   wdat;
    logic [3:0]    wstb;
    logic [AW-1:0] raddr;
    logic [31:0]   exp;
  } vec_t;

  vec_t tbl[14];

  initial begin
    logic [31:0]   rd;
    logic [AW-1:0] a;
    logic [31:0]   d;
    awaddr = '0; araddr = '0; awprot = '0; arprot = '0; awvalid = 0; wvalid = 0;
    wdata = '0; wstrb = '0; bready = 0; arvalid = 0; rready = 0; ch_irq = '0; ch_buf = '0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("reset_ctl", {22'd0, awready, wready, bvalid, bresp, arready, rvalid, rresp, irq_o}, 32'd0);
    check("reset_rdata", rdata, 32'd0);

    // register-level vectors: optional write, then read back
    tbl[0]  = '{1'b0, 6'h00, 32'h0,         4'h0, 6'h0C, ID_VAL};
    tbl[1]  = '{1'b0, 6'h00, 32'h0,         4'h0, 6'h00, 32'h0};
    tbl[2]  = '{1'b0, 6'h00, 32'h0,         4'h0, 6'h04, 32'h0};
    tbl[3]  = '{1'b0, 6'h00, 32'h0,         4'h0, 6'h08, 32'h0};
    tbl[4]  = '{1'b1, 6'h04, 32'hFFFF_FFFF, 4'b0010, 6'h04, 32'h0};
    tbl[5]  = '{1'b1, 6'h04, 32'h0000_000A, 4'b0001, 6'h04, 32'hA};
    tbl[6]  = '{1'b1, 6'h07, 32'hFFFF_FFF5, 4'hF, 6'h04, 32'h5};
    tbl[7]  = '{1'b1, 6'h08, 32'h0000_0001, 4'b0001, 6'h08, 32'h1};
    tbl[8]  = '{1'b1, 6'h08, 32'hFFFF_FFFE, 4'b1110, 6'h08, 32'h1};
    tbl[9]  = '{1'b1, 6'h0C, 32'h0,         4'hF, 6'h0E, ID_VAL};
    tbl[10] = '{1'b1, 6'h30, 32'hFFFF_FFFF, 4'hF, 6'h30, 32'h0};
    tbl[11] = '{1'b1, 6'h20, 32'hFFFF_FFFF, 4'hF, 6'h20, 32'h0};
    tbl[12] = '{1'b1, 6'h08, 32'h0000_0002, 4'hF, 6'h08, 32'h0};
    tbl[13] = '{1'b1, 6'h00, 32'h0000_00FF, 4'hF, 6'h10, 32'h0};
    for (int i = 0; i < 14; i++) begin
      if (tbl[i].do_wr) axi_write(tbl[i].waddr, tbl[i].wdat, tbl[i].wstb, '0);
      axi_read(tbl[i].raddr, rd);
      check($sformatf("vec%0d", i), rd, tbl[i].exp);
    end

    // interrupt latency and W1C
    axi_write(6'h04, 32'h1, 4'hF, '0);
    axi_write(6'h08, 32'h1, 4'hF, '0);
    ev_next = 4'b0001; buf_next = 8'h02;
    tick();
    check("irq_lat1", {31'd0, irq_o}, 32'd0);
    tick();
    check("irq_lat2", {31'd0, irq_o}, 32'd1);
    axi_read(6'h10, rd);
    check("ch0_after_event", rd, 32'h0001_0002);
    axi_write(6'h00, 32'h1, 4'hF, '0);
    check("irq_after_w1c", {31'd0, irq_o}, 32'd0);

    // missed counting, CHn write, saturation
    buf_next = 8'h05;
    repeat (3) begin ev_next = 4'b0100; tick(); end
    axi_read(6'h18, rd);
    check("ch2_three", rd, 32'h0003_0205);
    axi_write(6'h18, 32'h0, 4'hF, '0);
    axi_read(6'h18, rd);
    check("ch2_missed_clr", rd, 32'h0003_0005);
    buf_next = 8'h07;
    repeat (300) begin ev_next = 4'b0100; tick(); end
    axi_read(6'h18, rd);
    check("ch2_saturate", rd, 32'h012F_FF07);

    // same-cycle collisions
    buf_next = 8'h09; ev_next = 4'b0010;
    tick();
    axi_write(6'h00, 32'h2, 4'hF, 4'b0010);
    axi_read(6'h00, rd);
    check("w1c_vs_event_status", rd, 32'h6);
    axi_read(6'h14, rd);
    check("w1c_vs_event_ch1", rd, 32'h0002_0009);
    axi_write(6'h08, 32'h3, 4'hF, 4'b0010);
    axi_read(6'h14, rd);
    check("clr_vs_event_ch1", rd, 32'h0001_0109);
    axi_read(6'h18, rd);
    check("clr_ch2", rd, 32'h0000_0007);
    axi_read(6'h08, rd);
    check("ctrl_bit1_reads0", rd, 32'h1);
    axi_write(6'h14, 32'h0, 4'hF, 4'b0010);
    axi_read(6'h14, rd);
    check("chwr_vs_event_ch1", rd, 32'h0002_0109);

    // AW ahead of W, slow BREADY, concurrent read
    awaddr = 6'h04; wdata = 32'h3; wstrb = 4'hF; awvalid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("no_early_ready", {30'd0, awready, wready}, 32'd0);
    end
    wvalid = 1'b1;
    for (int i = 0; i < 20 && !awready; i++) tick();
    check("late_w_ready", {30'd0, awready, wready}, 32'd3);
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    araddr = 6'h04; arvalid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("bvalid_held", {31'd0, bvalid}, 32'd1);
      if (rvalid) arvalid = 1'b0;
    end
    check("conc_rvalid", {31'd0, rvalid}, 32'd1);
    check("conc_rdata", rdata, 32'h3);
    if (exp_q.size() > 0) check("conc_rdata_model", rdata, exp_q.pop_front());
    bready = 1'b1; rready = 1'b1;
    tick();
    check("b_r_done", {30'd0, bvalid, rvalid}, 32'd0);
    bready = 1'b0; rready = 1'b0;

    // randomized traffic against the model
    rand_ev = 1'b1;
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 7))
        0: a = 6'h00;  1: a = 6'h04;  2: a = 6'h08;  3: a = 6'h10;
        4: a = 6'h14;  5: a = 6'h18;  6: a = 6'h1C;
        default: a = 6'($urandom_range(0, 63));
      endcase
      d = $urandom;
      if (a[5:2] == 4'd2 && $urandom_range(0, 7) != 0) d[1] = 1'b0;
      case ($urandom_range(0, 3))
        0, 1: axi_write(a, d, 4'($urandom), '0);
        2: axi_read(6'($urandom_range(0, 63)), rd);
        default: repeat ($urandom_range(1, 4)) tick();
      endcase
    end
    rand_ev = 1'b0;
    tick();

    // reset in the middle of a write
    awaddr = 6'h04; wdata = 32'hF; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    tick();
    check("ready_before_rst", {30'd0, awready, wready}, 32'd3);
    #2 rst_n = 1'b0;
    #1 check("ready_async_rst", {28'd0, awready, wready, bvalid, irq_o}, 32'd0);
    awvalid = 1'b0; wvalid = 1'b0;
    model_reset();
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    axi_read(6'h04, rd);
    check("enable_after_rst", rd, 32'h0);
    axi_read(6'h00, rd);
    check("status_after_rst", rd, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
